// File: rtl/alvo_colisao.sv
// alvo_colisao -- rectangular target that answers a projectile.
//
// Detects overlap between a round projectile (centre + radius) and a
// rectangular target, returns a one-cycle `acertou` pulse on a registered
// hit edge, tracks the target's lives, drives the renderer blink flag and
// raises game over once all lives are spent.
//
// Optional feature macro: ALVO_ESCUDO_EN
//   defined   -> a shield absorbs the first hit after reset / reiniciarJogo
//                (pulse + blink, no life lost).
//   undefined -> every hit costs a life.
//
// Ports:
//   CLOCK_50       in   system clock (50 MHz)
//   reset          in   asynchronous, active-high
//   pausa          in   freezes tick counter and FSM, hits ignored
//   reiniciarJogo  in   synchronous reload of lives and state
//   bola_x/bola_y  in   projectile centre (screen coordinates)
//   bola_raio      in   projectile radius
//   alvo_x/alvo_y  in   target top-left corner (screen coordinates)
//   acertou        out  one-cycle hit pulse
//   alvo_vivo      out  1 while VIVO or ATINGIDO
//   piscar         out  1 = draw the target this frame
//   vidas          out  remaining lives
//   fim_de_jogo    out  1 in MORTO
module alvo_colisao #(
  parameter int LARGURA     = 30,
  parameter int ALTURA      = 20,
  parameter int VIDAS_INI   = 3,
  parameter int DIV_TICK    = 200000,
  parameter int PISCA_TICKS = 64
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic [9:0] bola_x,
  input  logic [9:0] bola_y,
  input  logic [9:0] bola_raio,
  input  logic [9:0] alvo_x,
  input  logic [9:0] alvo_y,
  output logic       acertou,
  output logic       alvo_vivo,
  output logic       piscar,
  output logic [2:0] vidas,
  output logic       fim_de_jogo
);

  // Tick counter must hold DIV_TICK-1; blink counter needs at least bit 3
  // because the blink phase is taken from it.
  localparam int TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int BW = (PISCA_TICKS > 16) ? $clog2(PISCA_TICKS) : 4;

  localparam logic [TW-1:0] TICK_ULT  = TW'(DIV_TICK - 1);
  localparam logic [BW-1:0] PISCA_ULT = BW'(PISCA_TICKS - 1);
  localparam logic [2:0]    VIDAS_RST = 3'(VIDAS_INI);

  typedef enum logic [1:0] {VIVO, ATINGIDO, MORTO} estado_t;

  estado_t       estado;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [BW-1:0] pisca_cnt;
  logic [BW-1:0] pisca_prox;
  logic          ov, ov_q, ov_qq, hit;
  logic [10:0]   bx, by, br, ax, ay;
  logic          estacionado;
`ifdef ALVO_ESCUDO_EN
  logic          escudo;
`endif

  // ---------------- game tick ----------------
  assign tick = !pausa && (tick_cnt == TICK_ULT);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                tick_cnt <= '0;
    else if (reiniciarJogo)   tick_cnt <= '0;
    else if (!pausa)          tick_cnt <= (tick_cnt == TICK_ULT) ? '0 : tick_cnt + 1'b1;
  end

  // ---------------- overlap ----------------
  // Widened to 11 bits so screen coordinate + radius sums do not wrap.
  assign bx = {1'b0, bola_x};
  assign by = {1'b0, bola_y};
  assign br = {1'b0, bola_raio};
  assign ax = {1'b0, alvo_x};
  assign ay = {1'b0, alvo_y};

  // The projectile parks at (>=1000, >=1000) when it is not in flight.
  assign estacionado = (bola_x >= 10'd1000) || (bola_y >= 10'd1000);

  assign ov = !estacionado &&
              (bx + br >= ax) && (bx <= ax + 11'(LARGURA) + br) &&
              (by + br >= ay) && (by <= ay + 11'(ALTURA) + br);

  // ov_q tracks overlap even under pausa, so releasing pausa with the
  // projectile already inside does not fabricate an edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ov_q  <= 1'b0;
      ov_qq <= 1'b0;
    end else if (reiniciarJogo) begin
      ov_q  <= 1'b0;
      ov_qq <= 1'b0;
    end else begin
      ov_q  <= ov;
      ov_qq <= ov_q;
    end
  end

  assign hit        = ov_q && !ov_qq;
  assign pisca_prox = pisca_cnt + 1'b1;

  // ---------------- target FSM ----------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado      <= VIVO;
      vidas       <= VIDAS_RST;
      pisca_cnt   <= '0;
      acertou     <= 1'b0;
      piscar      <= 1'b1;
      alvo_vivo   <= 1'b1;
      fim_de_jogo <= 1'b0;
`ifdef ALVO_ESCUDO_EN
      escudo      <= 1'b1;
`endif
    end else if (reiniciarJogo) begin
      estado      <= VIVO;
      vidas       <= VIDAS_RST;
      pisca_cnt   <= '0;
      acertou     <= 1'b0;
      piscar      <= 1'b1;
      alvo_vivo   <= 1'b1;
      fim_de_jogo <= 1'b0;
`ifdef ALVO_ESCUDO_EN
      escudo      <= 1'b1;
`endif
    end else if (pausa) begin
      acertou <= 1'b0;
    end else begin
      acertou <= 1'b0;
      case (estado)
        VIVO: begin
          piscar <= 1'b1;
          if (hit) begin
            acertou   <= 1'b1;
            pisca_cnt <= '0;
            estado    <= ATINGIDO;
`ifdef ALVO_ESCUDO_EN
            if (escudo)           escudo <= 1'b0;
            else if (vidas != 0)  vidas  <= vidas - 3'd1;
`else
            if (vidas != 0)       vidas  <= vidas - 3'd1;
`endif
          end
        end
        ATINGIDO: begin
          if (tick) begin
            if (pisca_cnt == PISCA_ULT) begin
              if (vidas == 3'd0) begin
                estado      <= MORTO;
                alvo_vivo   <= 1'b0;
                piscar      <= 1'b0;
                fim_de_jogo <= 1'b1;
              end else begin
                estado <= VIVO;
                piscar <= 1'b1;
              end
            end else begin
              pisca_cnt <= pisca_prox;
              // Draw for 8 ticks, hide for 8 ticks, ...
              piscar    <= ~pisca_prox[3];
            end
          end
        end
        MORTO: begin
          alvo_vivo   <= 1'b0;
          piscar      <= 1'b0;
          fim_de_jogo <= 1'b1;
        end
        default: estado <= VIVO;
      endcase
    end
  end

endmodule

// File: tb/tb_alvo_colisao.sv
module tb_alvo_colisao;
  localparam int DIV = 4;
  localparam int PT  = 20;
  localparam int VI  = 3;
  localparam int LG  = 30;
  localparam int AL  = 20;
`ifdef ALVO_ESCUDO_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif
  localparam int ALIVE = 0, HITM = 1, DEAD = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset, pausa, reiniciarJogo;
  logic [9:0] bola_x, bola_y, bola_raio, alvo_x, alvo_y;
  logic       acertou, alvo_vivo, piscar, fim_de_jogo;
  logic [2:0] vidas;

  alvo_colisao #(.LARGURA(LG), .ALTURA(AL), .VIDAS_INI(VI),
                 .DIV_TICK(DIV), .PISCA_TICKS(PT)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa),
    .reiniciarJogo(reiniciarJogo), .bola_x(bola_x), .bola_y(bola_y),
    .bola_raio(bola_raio), .alvo_x(alvo_x), .alvo_y(alvo_y),
    .acertou(acertou), .alvo_vivo(alvo_vivo), .piscar(piscar),
    .vidas(vidas), .fim_de_jogo(fim_de_jogo));

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---- reference model: game rules in plain arithmetic ----
  int m_mode, m_lives, m_ticks, m_phase;
  bit m_shield, m_ac;
  bit seen1, seen2;   // overlap seen 1 and 2 edges ago
  int pulses;
  bit prev_ac;

  function automatic bit overlap(int bx, int by, int r, int ax, int ay);
    if (bx >= 1000 || by >= 1000) return 1'b0;
    return (bx + r >= ax) && (bx <= ax + LG + r) && (by + r >= ay) && (by <= ay + AL + r);
  endfunction

  task automatic model_init();
    m_mode = ALIVE; m_lives = VI; m_ticks = 0; m_phase = 0;
    m_shield = ESC; m_ac = 0; seen1 = 0; seen2 = 0;
  endtask

  // Called right after a rising edge, inputs still hold their pre-edge values.
  task automatic model_edge();
    bit tk, hit, ovn;
    tk  = !pausa && (m_phase == DIV - 1);
    hit = seen1 && !seen2;
    ovn = overlap(bola_x, bola_y, bola_raio, alvo_x, alvo_y);
    if (reiniciarJogo) begin
      model_init();
    end else begin
      if (!pausa) m_phase = (m_phase + 1) % DIV;
      seen2 = seen1; seen1 = ovn;
      m_ac = 0;
      if (!pausa) begin
        if (m_mode == ALIVE && hit) begin
          m_ac = 1;
          if (m_shield) m_shield = 0;
          else if (m_lives > 0) m_lives--;
          m_ticks = 0;
          m_mode = HITM;
        end else if (m_mode == HITM && tk) begin
          if (m_ticks == PT - 1) m_mode = (m_lives == 0) ? DEAD : ALIVE;
          else m_ticks++;
        end
      end
    end
  endtask

  task automatic compare_all();
    int exp_pisca;
    exp_pisca = (m_mode == ALIVE) ? 1 : (m_mode == DEAD) ? 0 : (((m_ticks / 8) % 2) == 0);
    chk("acertou",     acertou,     m_ac);
    chk("vidas",       vidas,       m_lives);
    chk("piscar",      piscar,      exp_pisca);
    chk("alvo_vivo",   alvo_vivo,   m_mode != DEAD);
    chk("fim_de_jogo", fim_de_jogo, m_mode == DEAD);
    if (prev_ac) chk("no_double_pulse", acertou, 1'b0);
    prev_ac = acertou;
    if (acertou === 1'b1) pulses++;
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic park();
    bola_x = 10'd1000 + 10'($urandom_range(0, 23));
    bola_y = 10'd1000 + 10'($urandom_range(0, 23));
  endtask

  initial begin
    int p0;
    reset = 1; pausa = 0; reiniciarJogo = 0;
    alvo_x = 300; alvo_y = 100; bola_raio = 5; park();
    prev_ac = 0; pulses = 0;
    model_init();
    #1;
    chk("rst_vidas", vidas, VI);
    chk("rst_piscar", piscar, 1);
    chk("rst_acertou", acertou, 0);
    chk("rst_vivo", alvo_vivo, 1);
    chk("rst_fim", fim_de_jogo, 0);
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50); reset = 0;

    // 1: parked projectile never hits
    p0 = pulses;
    cyc(20);
    chk("parked_no_pulse", pulses - p0, 0);

    // 2: approach from below, one pulse, blink, back to VIVO
    bola_x = 315; bola_raio = 5; p0 = pulses;
    for (int y = 140; y >= 120; y--) begin bola_y = 10'(y); cyc(1); end
    cyc(90);
    chk("approach_one_pulse", pulses - p0, 1);
    chk("approach_vidas", vidas, ESC ? 3 : 2);
    chk("approach_vivo_again", piscar, 1);

    // 3: hit until MORTO, then another overlap gives nothing
    for (int k = 0; k < (ESC ? 3 : 2); k++) begin
      park(); cyc(3);
      bola_x = 315; bola_y = 110; cyc(90);
    end
    chk("dead_fim", fim_de_jogo, 1);
    chk("dead_vidas", vidas, 0);
    p0 = pulses;
    park(); cyc(3); bola_x = 315; bola_y = 110; cyc(6);
    chk("dead_no_pulse", pulses - p0, 0);

    // 5: reiniciarJogo on the cycle the registered overlap rises
    park(); cyc(3);
    bola_x = 300 - 5; bola_y = 100;   // touching corner, boundary case
    cyc(1);
    reiniciarJogo = 1; p0 = pulses; cyc(1); reiniciarJogo = 0;
    chk("restart_no_pulse", pulses - p0, 0);
    chk("restart_vidas", vidas, VI);
    chk("restart_vivo", alvo_vivo, 1);
    park(); cyc(90);

    // boundary: one pixel short of touching gives no hit
    p0 = pulses;
    bola_x = 300 - 6; bola_y = 100; bola_raio = 5; cyc(6);
    bola_x = 300; bola_y = 100 + AL + 6; cyc(6);
    chk("edge_miss", pulses - p0, 0);
    park(); cyc(3);

    // 4: pausa while entering overlap, then release while still inside
    reiniciarJogo = 1; cyc(1); reiniciarJogo = 0;
    p0 = pulses;
    pausa = 1; cyc(2); bola_x = 320; bola_y = 110; cyc(10);
    pausa = 0; cyc(10);
    chk("pause_no_pulse", pulses - p0, 0);
    park(); cyc(3);

    // random phases
    for (int ph = 0; ph < 250; ph++) begin
      int len, sel;
      len = $urandom_range(1, 30);
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) begin
        alvo_x = 10'($urandom_range(200, 400));
        alvo_y = 10'($urandom_range(50, 150));
      end
      bola_raio = 10'($urandom_range(0, 15));
      if (sel < 3) park();
      else begin
        bola_x = 10'(int'(alvo_x) + $urandom_range(0, LG + 40) - 20);
        bola_y = 10'(int'(alvo_y) + $urandom_range(0, AL + 40) - 20);
      end
      pausa = ($urandom_range(0, 9) == 0);
      reiniciarJogo = ($urandom_range(0, 19) == 0);
      cyc(1);
      reiniciarJogo = 0;
      cyc(len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
